// File: rtl/spi_i2s_tx_fifo_ctrl.sv
// rtl/spi_i2s_tx_fifo_ctrl.sv - SPI/I2S transmit FIFO controller and enable/disable sequencer
// Optional status-word substitution during register-read commands: SPI_I2S_TXF_STA_EN
module spi_i2s_tx_fifo_ctrl #(
    parameter int DEPTH   = 8,
    parameter int TXE_LVL = 2
) (
    input  logic        i2s_clk_shft,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wr_en,
    input  logic [31:0] wr_dat,
    input  logic        tx_fifo_acq,
    input  logic        tx_shift_empty,
    input  logic        sel_sta,
    input  logic        clr_flags,
    output logic [31:0] tx_fifo_dat,
    output logic [3:0]  tx_fifo_fill,
    output logic        wr_full,
    output logic [31:0] tx_sta_reg,
    output logic        ovr,
    output logic        udr,
    output logic        irq_txe
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] FULL_LVL = 4'(DEPTH);
    localparam logic [3:0] TXE_THR  = 4'(TXE_LVL);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_UDR   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [3:0]    fill;
    logic          full, empty, pop_ok, draining, flush;
    logic          push, pop, ovr_set, udr_set, sta_sel;
    logic [31:0]   sta_word;

    assign full  = (fill == FULL_LVL);
    assign empty = (fill == 4'd0);

`ifdef SPI_I2S_TXF_STA_EN
    assign sta_sel = sel_sta;
`else
    logic unused_sel_sta;
    assign unused_sel_sta = sel_sta;
    assign sta_sel        = 1'b0;
`endif

    // A pop at full frees the slot the simultaneous push lands in.
    assign pop     = tx_fifo_acq && !empty && pop_ok && !sta_sel;
    assign push    = wr_en && !draining && (!full || pop);
    assign ovr_set = wr_en && full && !pop && !draining;
    assign udr_set = tx_fifo_acq && empty && (state == ST_RUN) && !sta_sel;
    assign flush   = draining && tx_shift_empty;

    always_ff @(posedge i2s_clk_shft or negedge rst_n) begin
        if (!rst_n) state <= ST_OFF;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_OFF:   if (en) state_nxt = ST_RUN;
            ST_RUN:   if (!en) state_nxt = ST_DRAIN;
                      else if (udr_set) state_nxt = ST_UDR;
            ST_UDR:   if (!en) state_nxt = ST_DRAIN;
                      else if (push) state_nxt = ST_RUN;
            ST_DRAIN: if (tx_shift_empty) state_nxt = ST_OFF;
            default:  state_nxt = ST_OFF;
        endcase
    end

    always_comb begin
        pop_ok   = 1'b0;
        draining = 1'b0;
        irq_txe  = 1'b0;
        unique case (state)
            ST_RUN:   begin pop_ok = 1'b1; irq_txe = (fill <= TXE_THR); end
            ST_UDR:   irq_txe = (fill <= TXE_THR);
            ST_DRAIN: begin pop_ok = 1'b1; draining = 1'b1; end
            default:  ;
        endcase
    end

    assign wr_full = full || draining;

    always_ff @(posedge i2s_clk_shft or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= 4'd0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= 4'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      fill <= fill + 4'd1;
            else if (pop && !push) fill <= fill - 4'd1;
        end
    end

    always_ff @(posedge i2s_clk_shft) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end

    // Set events outrank a same-cycle clear.
    always_ff @(posedge i2s_clk_shft or negedge rst_n) begin
        if (!rst_n) begin
            ovr <= 1'b0;
            udr <= 1'b0;
        end else begin
            ovr <= ovr_set || (ovr && !clr_flags);
            udr <= udr_set || (udr && !clr_flags);
        end
    end

    assign sta_word = {22'h0, state, udr, ovr, empty, full, fill};

`ifdef SPI_I2S_TXF_STA_EN
    assign tx_sta_reg = sta_word;
`else
    assign tx_sta_reg = 32'h0;
`endif

    always_comb begin
        tx_fifo_dat = 32'h0;
        if (sta_sel)
            tx_fifo_dat = sta_word;
        else if (!empty && state != ST_UDR)
            tx_fifo_dat = mem[rd_ptr];
    end

    assign tx_fifo_fill = fill;

endmodule

// File: tb/tb_spi_i2s_tx_fifo_ctrl.sv
// tb/tb_spi_i2s_tx_fifo_ctrl.sv - scoreboard bench for spi_i2s_tx_fifo_ctrl (DEPTH=8, TXE_LVL=2)
module tb_spi_i2s_tx_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, en, wr_en, tx_fifo_acq, tx_shift_empty, sel_sta, clr_flags;
    logic [31:0] wr_dat;
    logic [31:0] tx_fifo_dat, tx_sta_reg;
    logic [3:0]  tx_fifo_fill;
    logic        wr_full, ovr, udr, irq_txe;

    int          checks = 0;
    int          errors = 0;
    bit          no_pop = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    spi_i2s_tx_fifo_ctrl #(.DEPTH(8), .TXE_LVL(2)) dut (
        .i2s_clk_shft  (clk),
        .rst_n         (rst_n),
        .en            (en),
        .wr_en         (wr_en),
        .wr_dat        (wr_dat),
        .tx_fifo_acq   (tx_fifo_acq),
        .tx_shift_empty(tx_shift_empty),
        .sel_sta       (sel_sta),
        .clr_flags     (clr_flags),
        .tx_fifo_dat   (tx_fifo_dat),
        .tx_fifo_fill  (tx_fifo_fill),
        .wr_full       (wr_full),
        .tx_sta_reg    (tx_sta_reg),
        .ovr           (ovr),
        .udr           (udr),
        .irq_txe       (irq_txe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && tx_fifo_acq && tx_fifo_fill != 4'd0 && !no_pop) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h expected none", tx_fifo_dat);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (tx_fifo_dat !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %h expected %h", tx_fifo_dat, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input bit queued);
        wr_en  = 1'b1;
        wr_dat = d;
        if (queued) exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic acq();
        tx_fifo_acq = 1'b1;
        tick();
        tx_fifo_acq = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_dat = 32'h0; tx_fifo_acq = 1'b0;
        tx_shift_empty = 1'b0; sel_sta = 1'b0; clr_flags = 1'b0;
        repeat (3) tick();
        chk("rst_fill", 32'(tx_fifo_fill), 32'd0);
        chk("rst_dat", tx_fifo_dat, 32'h0);
        chk("rst_flags", {28'h0, wr_full, ovr, udr, irq_txe}, 32'h0);
`ifdef SPI_I2S_TXF_STA_EN
        chk("rst_sta", tx_sta_reg, 32'h20);
`else
        chk("rst_sta", tx_sta_reg, 32'h0);
`endif
        rst_n = 1'b1;
        tick();

        // Preload in OFF, then enable and pop.
        for (int i = 1; i <= 3; i++) push(32'hA5A5_0000 + 32'(i), 1'b1);
        chk("preload_fill", 32'(tx_fifo_fill), 32'd3);
        chk("preload_irq_off", 32'(irq_txe), 32'd0);
        en = 1'b1;
        tick();
        chk("run_irq_fill3", 32'(irq_txe), 32'd0);
        for (int i = 2; i >= 0; i--) begin
            acq();
            chk("preload_fill_step", 32'(tx_fifo_fill), 32'(i));
        end
        chk("preload_irq", 32'(irq_txe), 32'd1);
        chk("preload_udr", 32'(udr), 32'd0);
`ifndef SPI_I2S_TXF_STA_EN
        chk("sta_tied", tx_sta_reg, 32'h0);
`endif

        // Underrun and recovery.
        acq();
        chk("udr_set", 32'(udr), 32'd1);
        chk("udr_dat", tx_fifo_dat, 32'h0);
        chk("udr_irq", 32'(irq_txe), 32'd1);
        push(32'h1234_5678, 1'b1);
        chk("udr_recover_fill", 32'(tx_fifo_fill), 32'd1);
        chk("udr_recover_dat", tx_fifo_dat, 32'h1234_5678);
        acq();
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("udr_clr", 32'(udr), 32'd0);
        chk("udr_no_ovr", 32'(ovr), 32'd0);

        // Overrun: ninth word dropped.
        for (int i = 0; i < 9; i++) push(32'hB000_0000 + 32'(i), i < 8);
        chk("ovr_fill", 32'(tx_fifo_fill), 32'd8);
        chk("ovr_full", 32'(wr_full), 32'd1);
        chk("ovr_set", 32'(ovr), 32'd1);
        chk("ovr_irq", 32'(irq_txe), 32'd0);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        chk("ovr_clr", 32'(ovr), 32'd0);

        // Simultaneous push and pop at full.
        tx_fifo_acq = 1'b1;
        push(32'hC0DE_0009, 1'b1);
        tx_fifo_acq = 1'b0;
        chk("simul_fill", 32'(tx_fifo_fill), 32'd8);
        chk("simul_ovr", 32'(ovr), 32'd0);
        repeat (8) acq();
        chk("simul_drained", 32'(tx_fifo_fill), 32'd0);

        // Disable with words queued: drain then flush.
        push(32'hD000_0001, 1'b0);
        push(32'hD000_0002, 1'b0);
        en = 1'b0;
        tick();
        chk("drain_full", 32'(wr_full), 32'd1);
        chk("drain_fill", 32'(tx_fifo_fill), 32'd2);
        chk("drain_irq", 32'(irq_txe), 32'd0);
        push(32'hD000_0003, 1'b0);
        chk("drain_drop_fill", 32'(tx_fifo_fill), 32'd2);
        chk("drain_drop_ovr", 32'(ovr), 32'd0);
        tx_shift_empty = 1'b1;
        tick();
        tx_shift_empty = 1'b0;
        chk("flush_fill", 32'(tx_fifo_fill), 32'd0);
        chk("flush_full", 32'(wr_full), 32'd0);
        chk("flush_dat", tx_fifo_dat, 32'h0);

        // OFF ignores acq; async reset discards contents.
        push(32'hE000_0001, 1'b0);
        chk("off_dat", tx_fifo_dat, 32'hE000_0001);
        no_pop = 1'b1;
        acq();
        no_pop = 1'b0;
        chk("off_acq_ignored", 32'(tx_fifo_fill), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_fill", 32'(tx_fifo_fill), 32'd0);
        chk("async_rst_dat", tx_fifo_dat, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef SPI_I2S_TXF_STA_EN
        en = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) push(32'hF000_0000 + 32'(i), i < 8);
        repeat (5) acq();
        sel_sta = 1'b1;
        no_pop  = 1'b1;
        #1;
        chk("sta_dat", tx_fifo_dat, 32'h0000_0143);
        acq();
        chk("sta_no_pop", 32'(tx_fifo_fill), 32'd3);
        sel_sta = 1'b0;
        no_pop  = 1'b0;
        repeat (3) acq();
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_i2s_tx_fifo_ctrl.md
# spi_i2s_tx_fifo_ctrl

Transmit-side FIFO controller and sequencer for the SPI/I2S shifter. Accepts 32-bit words from the register side, presents them to the shifter through the `tx_fifo_dat` / `tx_fifo_fill` / `tx_fifo_acq` handshake, and tracks overrun and underrun. It also sequences enable and disable so that an in-flight word completes before a flush. Optionally it substitutes a status word for FIFO data during SPI slave register-read commands.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of 2, 2..8 (fill counter is 4 bits)
- TXE_LVL, 2, `irq_txe` asserts when fill <= TXE_LVL

Ports:
- i2s_clk_shft  in  1  shifter clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  transfer enable (spe or i2se from the register block)
- wr_en  in  1  push request, one word per cycle
- wr_dat  in  32  push data
- tx_fifo_acq  in  1  shifter pop pulse; `tx_fifo_dat` is consumed on this edge
- tx_shift_empty  in  1  shifter has no word in flight
- sel_sta  in  1  shifter is serving a register-read command (0x80/0x98)
- clr_flags  in  1  clears the sticky ovr/udr flags
- tx_fifo_dat  out  32  head word, or the substitute word
- tx_fifo_fill  out  4  occupancy, 0..DEPTH
- wr_full  out  1  push blocked
- tx_sta_reg  out  32  status word
- ovr  out  1  sticky overrun flag
- udr  out  1  sticky underrun flag
- irq_txe  out  1  low-water request

## Operation
- Storage is DEPTH x 32, with rd_ptr/wr_ptr wrapping modulo DEPTH. Fill is a registered counter.
- Show-ahead: `tx_fifo_dat` = mem[rd_ptr] while fill > 0; otherwise 32'h0.
- Pop on `tx_fifo_acq` while fill > 0, in states RUN and DRAIN only.
- Push on `wr_en` && !wr_full.
- Simultaneous push and pop: both happen and fill is unchanged. This also applies at fill == DEPTH.
- `wr_full` = (fill == DEPTH) || state == DRAIN.
- `ovr` sets on `wr_en` && fill == DEPTH with no pop in the same cycle; the word is dropped. A `wr_en` during DRAIN is dropped silently.
- `udr` sets on `tx_fifo_acq` while fill == 0 in RUN. A push in the same cycle is not bypassed to the output.
- `clr_flags` clears ovr/udr. A set event in the same cycle wins.
- State machine, 2-bit encoding OFF=0, RUN=1, UDR=2, DRAIN=3:
  - OFF: pushes accepted (preload), acq ignored. en=1 -> RUN.
  - RUN: en=0 -> DRAIN. acq with fill==0 -> UDR.
  - UDR: tx_fifo_dat = 0, acq ignored. Push -> RUN on the next edge. en=0 -> DRAIN.
  - DRAIN: pops continue. tx_shift_empty=1 -> pointers and fill cleared on that edge -> OFF.
- `irq_txe` = (state RUN or UDR) && fill <= TXE_LVL.
- `tx_sta_reg` bit map:
  - [3:0] fill
  - [4] fill==DEPTH
  - [5] fill==0
  - [6] ovr
  - [7] udr
  - [9:8] state
  - [31:10] 0

## Timing
- Reset values: fill 0, pointers 0, state OFF, ovr/udr/irq_txe 0, wr_full 0, tx_fifo_dat 0, tx_sta_reg 32'h20.
- Push-to-visible latency: a word pushed into an empty FIFO appears on `tx_fifo_dat`, with fill=1, on the edge following the push.
- Pop: the head advances on the acq edge, and the new head is valid in the next cycle.
- Back-to-back acq on consecutive cycles is supported.
- The `tx_sta_reg`, `irq_txe` and `wr_full` outputs are combinational from registered state and have no added latency.
- An asynchronous reset mid-transfer discards all contents immediately.

## Configuration
- `SPI_I2S_TXF_STA_EN` defined: while `sel_sta`=1, `tx_fifo_dat` = `tx_sta_reg` and acq performs no pop and no udr check.
- `SPI_I2S_TXF_STA_EN` undefined: `sel_sta` is ignored and `tx_sta_reg` is tied to 32'h0, including its reset value.

## Test plan
- Preload in OFF: push 0xA5A5_0001..0003, then set en=1. Three acq pulses return the words in order, fill steps 3->2->1->0, and udr stays 0.
- Overrun: push 9 words with DEPTH=8 and no acq. Fill = 8, wr_full = 1, ovr = 1, and the 9th word is absent from the pops.
- Underrun: in RUN with fill=0, pulse acq. State goes to UDR, udr=1, tx_fifo_dat=0. Push 0x1234_5678: state returns to RUN and 0x1234_5678 is presented. clr_flags then gives udr=0.
- Simultaneous: at fill=8, assert wr_en and acq together. Fill stays 8, ovr stays 0, and the pushed word is popped last.
- Disable drain: drop en with 2 words queued and tx_shift_empty=0. State enters DRAIN and wr_full=1. Raising tx_shift_empty gives fill=0 and state OFF on the next edge.
- With `SPI_I2S_TXF_STA_EN` defined, fill=3, ovr=1 and state RUN, raise sel_sta and pulse acq. tx_fifo_dat = 32'h0000_0143 and fill stays 3.
